// File: rtl/strela_auto_cg_ctrl.sv
// Automatic clock-gating controller: tracks outstanding OBI transactions and gates the clock when idle.
// Optional macro STRELA_CG_STATS_EN builds a saturating counter of cycles spent gated.
module strela_auto_cg_ctrl #(
    parameter int NUM_PORTS   = 4,
    parameter int MAX_OUTST   = 4,
    parameter int IDLE_CYCLES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_en_i,
    input  logic                 en_i,
    input  logic                 auto_en_i,
    input  logic                 core_idle_i,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] gnt_i,
    input  logic [NUM_PORTS-1:0] rvalid_i,
    input  logic                 wake_i,
    output logic                 clk_o,
    output logic                 clk_en_o,
    output logic [1:0]           state_o,
    output logic                 outst_err_o,
    output logic [31:0]          gated_cycles_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
    localparam logic [15:0]      IDLE_MAX = 16'(IDLE_CYCLES);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } state_t;

    state_t                             state_q, state_d;
    logic [NUM_PORTS-1:0][CNT_W-1:0]    outst_q, outst_d;
    logic [NUM_PORTS-1:0]               incr, ovf, unf, busy;
    logic [15:0]                        idle_q, idle_d;
    logic                               quiet, idle_cond;
    logic                               gate_en_l;

    assign incr = req_i & gnt_i;

    // A grant and a response in the same cycle cancel; out-of-range moves hold and flag an error.
    always_comb begin
        outst_d = outst_q;
        ovf     = '0;
        unf     = '0;
        busy    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            busy[p] = (outst_q[p] != '0);
            if (incr[p] && !rvalid_i[p]) begin
                if (outst_q[p] == CNT_MAX) ovf[p] = 1'b1;
                else                       outst_d[p] = outst_q[p] + 1'b1;
            end else if (rvalid_i[p] && !incr[p]) begin
                if (outst_q[p] == '0) unf[p] = 1'b1;
                else                  outst_d[p] = outst_q[p] - 1'b1;
            end
        end
    end

    assign quiet     = ~|busy && ~|req_i;
    assign idle_cond = (state_q == RUN) && auto_en_i && core_idle_i && quiet;
    assign idle_d    = !idle_cond ? 16'd0 : ((idle_q == IDLE_MAX) ? idle_q : idle_q + 16'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:   if (!en_i || (idle_d == IDLE_MAX)) state_d = DRAIN;
            DRAIN: begin
                if (wake_i || (en_i && !core_idle_i)) state_d = RUN;
                else if (quiet)                       state_d = GATED;
            end
            GATED: if (wake_i || (en_i && (!auto_en_i || !core_idle_i))) state_d = WAKE;
            WAKE:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // The gate enable is registered from the next state so it always matches state_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            clk_en_o    <= 1'b1;
            idle_q      <= '0;
            outst_q     <= '0;
            outst_err_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_en_o    <= (state_d != GATED);
            idle_q      <= idle_d;
            outst_q     <= outst_d;
            outst_err_o <= outst_err_o | (|ovf) | (|unf);
        end
    end

    assign state_o = state_q;

    // Latch is transparent only while clk_i is low, so clk_o cannot glitch.
    always_latch begin
        if (!clk_i) gate_en_l = clk_en_o | test_en_i;
    end

    assign clk_o = clk_i & gate_en_l;

`ifdef STRELA_CG_STATS_EN
    logic [31:0] gated_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                       gated_q <= '0;
        else if ((state_q == GATED) && (gated_q != '1))    gated_q <= gated_q + 32'd1;
    end

    assign gated_cycles_o = gated_q;
`else
    assign gated_cycles_o = '0;
`endif

endmodule

// File: tb/tb_strela_auto_cg_ctrl.sv
// Self-checking bench for strela_auto_cg_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_strela_auto_cg_ctrl;

    localparam int NP = 4;
    localparam int MO = 4;
    localparam int IC = 16;
    localparam int S_RUN = 0, S_DRAIN = 1, S_GATED = 2, S_WAKE = 3;

    logic          clk = 1'b0;
    logic          rst_n, test_en, en, auto_en, core_idle, wake;
    logic [NP-1:0] req, gnt, rvalid;
    logic          clk_o, clk_en_o, outst_err_o;
    logic [1:0]    state_o;
    logic [31:0]   gated_cycles_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int clk_o_edges  = 0;

    int          m_state, m_idle;
    int          m_cnt [NP];
    bit          m_err;
    logic [31:0] m_gated;
    bit          exp_pulse;
    bit          quiet_mode;
    int          snap;

    strela_auto_cg_ctrl #(
        .NUM_PORTS  (NP),
        .MAX_OUTST  (MO),
        .IDLE_CYCLES(IC)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .test_en_i     (test_en),
        .en_i          (en),
        .auto_en_i     (auto_en),
        .core_idle_i   (core_idle),
        .req_i         (req),
        .gnt_i         (gnt),
        .rvalid_i      (rvalid),
        .wake_i        (wake),
        .clk_o         (clk_o),
        .clk_en_o      (clk_en_o),
        .state_o       (state_o),
        .outst_err_o   (outst_err_o),
        .gated_cycles_o(gated_cycles_o)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk_o) clk_o_edges <= clk_o_edges + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic a, input logic ci, input logic w,
                                 input logic [NP-1:0] r, input logic [NP-1:0] g, input logic [NP-1:0] v);
        en = e; auto_en = a; core_idle = ci; wake = w;
        req = r; gnt = g; rvalid = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic doReset(input logic e, input logic a, input logic ci);
        applyStimulus(e, a, ci, 1'b0, '0, '0, '0);
        test_en = 1'b0;
        rst_n   = 1'b0;
        tick(2);
        rst_n   = 1'b1;
    endtask

    // ---------------- behavioural model ----------------
    function automatic int cnt_next(int c, bit inc, bit dec);
        if (inc && !dec) return (c == MO) ? c : c + 1;
        if (dec && !inc) return (c == 0) ? 0 : c - 1;
        return c;
    endfunction

    function automatic bit any_err();
        for (int p = 0; p < NP; p++) begin
            bit inc = req[p] & gnt[p];
            if (inc && !rvalid[p] && m_cnt[p] == MO) return 1'b1;
            if (rvalid[p] && !inc && m_cnt[p] == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit quiet_now();
        for (int p = 0; p < NP; p++)
            if (m_cnt[p] != 0) return 1'b0;
        return (req == '0);
    endfunction

    function automatic int idle_next();
        if (m_state == S_RUN && auto_en && core_idle && quiet_now())
            return (m_idle + 1 > IC) ? IC : m_idle + 1;
        return 0;
    endfunction

    function automatic int state_next();
        case (m_state)
            S_RUN:   return (!en || idle_next() == IC) ? S_DRAIN : S_RUN;
            S_DRAIN: begin
                if (wake || (en && !core_idle)) return S_RUN;
                return quiet_now() ? S_GATED : S_DRAIN;
            end
            S_GATED: return (wake || (en && (!auto_en || !core_idle))) ? S_WAKE : S_GATED;
            default: return S_RUN;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= S_RUN;
            m_idle  <= 0;
            m_err   <= 1'b0;
            m_gated <= '0;
            for (int p = 0; p < NP; p++) m_cnt[p] <= 0;
        end else begin
            for (int p = 0; p < NP; p++) m_cnt[p] <= cnt_next(m_cnt[p], req[p] & gnt[p], rvalid[p]);
            m_err   <= m_err | any_err();
            m_idle  <= idle_next();
            m_state <= state_next();
            m_gated <= (m_state == S_GATED && m_gated != 32'hFFFF_FFFF) ? m_gated + 32'd1 : m_gated;
        end
    end

    function automatic logic [31:0] exp_gated();
`ifdef STRELA_CG_STATS_EN
        return m_gated;
`else
        return 32'd0;
`endif
    endfunction

    // Per-cycle comparison of registered outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("state_o", {30'd0, state_o}, 32'(m_state));
            checkOutput("clk_en_o", {31'd0, clk_en_o}, {31'd0, (m_state != S_GATED)});
            checkOutput("outst_err_o", {31'd0, outst_err_o}, {31'd0, m_err});
            checkOutput("gated_cycles_o", gated_cycles_o, exp_gated());
        end
    end

    // A clk_o pulse must appear exactly when the enable held during the preceding low phase was set.
    always begin
        @(posedge clk);
        exp_pulse = (m_state != S_GATED) | test_en;
        #1;
        if (rst_n) checkOutput("clk_o_pulse", {31'd0, clk_o}, {31'd0, exp_pulse});
    end

    initial begin
        rst_n = 1'b0;
        test_en = 1'b0;
        quiet_mode = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

        // Reset values and steady RUN with auto-gating disabled.
        doReset(1'b1, 1'b0, 1'b0);
        checkOutput("reset_state", {30'd0, state_o}, 32'd0);
        checkOutput("reset_clk_en", {31'd0, clk_en_o}, 32'd1);
        checkOutput("reset_err", {31'd0, outst_err_o}, 32'd0);
        checkOutput("reset_gated", gated_cycles_o, 32'd0);
        snap = clk_o_edges;
        tick(100);
        checkOutput("run100_pulses", 32'(clk_o_edges - snap), 32'd100);
        checkOutput("run100_state", {30'd0, state_o}, 32'd0);

        // Idle threshold: DRAIN after 16 idle cycles, GATED one cycle later.
        doReset(1'b1, 1'b1, 1'b1);
        tick(15);
        checkOutput("idle15_state", {30'd0, state_o}, 32'(S_RUN));
        tick(1);
        checkOutput("idle16_drain", {30'd0, state_o}, 32'(S_DRAIN));
        tick(1);
        checkOutput("idle17_gated", {30'd0, state_o}, 32'(S_GATED));
        checkOutput("gated_clk_en", {31'd0, clk_en_o}, 32'd0);
        snap = clk_o_edges;
        tick(40);
        checkOutput("gated_no_pulses", 32'(clk_o_edges - snap), 32'd0);
`ifdef STRELA_CG_STATS_EN
        checkOutput("gated40_stats", gated_cycles_o, 32'd40);
`else
        checkOutput("gated40_stats", gated_cycles_o, 32'd0);
`endif
        test_en = 1'b1;
        snap = clk_o_edges;
        tick(5);
        checkOutput("test_en_pulses", 32'(clk_o_edges - snap), 32'd5);
        test_en = 1'b0;
        wake = 1'b1;
        tick(1);
        checkOutput("wake_state", {30'd0, state_o}, 32'(S_WAKE));
        wake = 1'b0;
        tick(1);
        checkOutput("wake_run", {30'd0, state_o}, 32'(S_RUN));
        checkOutput("wake_clk_en", {31'd0, clk_en_o}, 32'd1);

        // Drain waits for all three responses on port 2.
        doReset(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100, '0);
        tick(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick(1);
        checkOutput("drain_enter", {30'd0, state_o}, 32'(S_DRAIN));
        for (int k = 1; k <= 3; k++) begin
            rvalid = 4'b0100;
            tick(1);
            checkOutput("drain_hold", {30'd0, state_o}, 32'(S_DRAIN));
            rvalid = '0;
            tick(1);
            checkOutput("drain_after_rvalid", {30'd0, state_o}, (k == 3) ? 32'(S_GATED) : 32'(S_DRAIN));
        end
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_state", {30'd0, state_o}, 32'(S_RUN));
        checkOutput("async_reset_clk_en", {31'd0, clk_en_o}, 32'd1);
        tick(1);
        rst_n = 1'b1;

        // Overflow saturates at 4 and latches the error flag.
        doReset(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, '0);
        tick(4);
        checkOutput("ovf_err_before", {31'd0, outst_err_o}, 32'd0);
        tick(1);
        checkOutput("ovf_err_after", {31'd0, outst_err_o}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 4'b0001);
        tick(4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick(2);
        checkOutput("ovf_drained_gated", {30'd0, state_o}, 32'(S_GATED));

        // Underflow holds at 0 and latches the error flag.
        doReset(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 4'b0010);
        tick(1);
        checkOutput("unf_err", {31'd0, outst_err_o}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick(2);
        checkOutput("unf_gated", {30'd0, state_o}, 32'(S_GATED));

        // Randomized traffic alternating busy and quiet phases.
        doReset(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) quiet_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            en        = ($urandom_range(0, 7) != 0);
            auto_en   = ($urandom_range(0, 5) != 0);
            core_idle = quiet_mode ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 0);
            wake      = quiet_mode ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 24) == 0);
            test_en   = ($urandom_range(0, 29) == 0);
            for (int p = 0; p < NP; p++) begin
                if (quiet_mode) begin
                    req[p]    = 1'b0;
                    gnt[p]    = 1'b0;
                    rvalid[p] = (m_cnt[p] > 0) && ($urandom_range(0, 2) == 0);
                end else begin
                    req[p]    = ($urandom_range(0, 3) == 0);
                    gnt[p]    = req[p] & ($urandom_range(0, 1) == 0);
                    rvalid[p] = (m_cnt[p] > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
                end
            end
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
